sha256_block_ctrl: RTL and testbench

Sequencing controller for the SHA-256 message-schedule datapath. Accepts 512-bit message blocks over a valid/ready handshake and fires the schedule engine's one-cycle start strobe with the block. It then tracks the 64 schedule words the engine emits one per cycle, and gives the round datapath a round index, the matching round constant, per-round valid, and end-of-block controls. It sits between the message padder and the schedule engine plus compression rounds.

---
 rtl/sha256_block_ctrl.sv | 105 ++++++++++
 tb/tb_sha256_block_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: block handshake, schedule start strobe and per-round sequencing for SHA-256.
// Define SHA256_BLK_CTRL_KROM_EN to drive o_round_k from an internal K ROM; otherwise it is tied to 0.
module sha256_block_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [511:0] i_blk,
  input  logic         i_blk_first,
  input  logic         i_abort,
  output logic         o_sched_enable,
  output logic [511:0] o_sched_block,
  output logic         o_round_valid,
  output logic [5:0]   o_round_idx,
  output logic [31:0]  o_round_k,
  output logic         o_first,
  output logic         o_accumulate,
  output logic         o_done,
  output logic         o_aborted,
  output logic         o_busy
);
  typedef enum logic [2:0] {IDLE, START, ROUNDS, FINAL, DRAIN} state_t;
  state_t       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic         ab_q, ab_d;
  logic         first_q, first_d;
  logic [511:0] blk_q, blk_d;
  always_comb begin
    state_d = IDLE;
    t_d     = '0;
    ab_d    = ab_q;
    first_d = first_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        state_d = i_blk_valid ? START : IDLE;
        blk_d   = i_blk_valid ? i_blk : blk_q;
        first_d = i_blk_valid ? i_blk_first : first_q;
        ab_d    = i_blk_valid ? 1'b0 : ab_q;
      end
      START: begin
        state_d = i_abort ? DRAIN : ROUNDS;
        ab_d    = i_abort;
      end
      ROUNDS: begin
        t_d     = t_q + 6'd1;
        state_d = (t_q == 6'd63) ? FINAL : (i_abort ? DRAIN : ROUNDS);
        ab_d    = ab_q | (i_abort && t_q != 6'd63);
      end
      // the terminal cycle is shared with normal blocks so both release ready at A+67
      DRAIN: begin
        t_d     = t_q + 6'd1;
        state_d = (t_q == 6'd63) ? FINAL : DRAIN;
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      ab_q    <= 1'b0;
      first_q <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ab_q    <= ab_d;
      first_q <= first_d;
      blk_q   <= blk_d;
    end
  end
  assign o_blk_ready    = state_q == IDLE;
  assign o_busy         = state_q != IDLE;
  assign o_sched_enable = state_q == START;
  assign o_round_valid  = state_q == ROUNDS;
  assign o_round_idx    = t_q;
  assign o_sched_block  = blk_q;
  assign o_first        = first_q;
  assign o_accumulate   = state_q == FINAL && !ab_q;
  assign o_done         = state_q == FINAL && !ab_q;
  assign o_aborted      = state_q == FINAL && ab_q;
`ifdef SHA256_BLK_CTRL_KROM_EN
  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] k_q;
  // indexed by next t so K lands on the same edge as the index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) k_q <= '0;
    else      k_q <= KROM[t_d];
  end
  assign o_round_k = k_q;
`else
  assign o_round_k = '0;
`endif
endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl: directed scenarios for sha256_block_ctrl with cycle-accurate expectations.
module tb_sha256_block_ctrl;
  logic         clk = 1'b0, rst = 1'b0;
  logic         i_blk_valid = 1'b0, i_blk_first = 1'b0, i_abort = 1'b0;
  logic [511:0] i_blk = '0;
  logic         o_blk_ready, o_sched_enable, o_round_valid, o_first;
  logic         o_accumulate, o_done, o_aborted, o_busy;
  logic [511:0] o_sched_block;
  logic [5:0]   o_round_idx;
  logic [31:0]  o_round_k;
  int checks = 0, errors = 0;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B2  = {16{32'hdeadbeef}};
  localparam logic [511:0] B3  = {16{32'h0badf00d}};

  sha256_block_ctrl dut (
    .clk(clk), .rst(rst), .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready),
    .i_blk(i_blk), .i_blk_first(i_blk_first), .i_abort(i_abort),
    .o_sched_enable(o_sched_enable), .o_sched_block(o_sched_block),
    .o_round_valid(o_round_valid), .o_round_idx(o_round_idx), .o_round_k(o_round_k),
    .o_first(o_first), .o_accumulate(o_accumulate), .o_done(o_done),
    .o_aborted(o_aborted), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // abort_c: cycle after accept in which i_abort is held (0 = none); armed: valid already high
  task automatic run_block(input string name, input logic [511:0] blk, input logic first,
                           input int abort_c, input logic armed, input logic hold,
                           input logic [511:0] nblk, input logic nfirst);
    logic eff, ev, ee, ed, ea, er;
    logic [5:0] ei;
    logic [31:0] ek;
    eff = abort_c >= 1 && abort_c <= 64;
    if (!armed) begin
      i_blk_valid = 1'b1; i_blk = blk; i_blk_first = first;
    end
    @(posedge clk); #1;
    if (hold) begin
      i_blk = nblk; i_blk_first = nfirst;
    end else i_blk_valid = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      ev = c >= 2 && c <= 65 && !(eff && c > abort_c);
      ei = (c >= 2 && c <= 65) ? 6'(c - 2) : 6'd0;
      ee = c == 1;
      ed = c == 66 && !eff;
      ea = c == 66 && eff;
      er = c == 67;
      checks++; if (o_round_valid !== ev) begin errors++; $display("FAIL %s valid c=%0d got %b exp %b", name, c, o_round_valid, ev); end
      checks++; if (o_round_idx !== ei) begin errors++; $display("FAIL %s idx c=%0d got %0d exp %0d", name, c, o_round_idx, ei); end
      checks++; if (o_sched_enable !== ee) begin errors++; $display("FAIL %s enable c=%0d got %b exp %b", name, c, o_sched_enable, ee); end
      checks++; if (o_done !== ed || o_accumulate !== ed) begin errors++; $display("FAIL %s done/acc c=%0d got %b/%b exp %b", name, c, o_done, o_accumulate, ed); end
      checks++; if (o_aborted !== ea) begin errors++; $display("FAIL %s aborted c=%0d got %b exp %b", name, c, o_aborted, ea); end
      checks++; if (o_blk_ready !== er || o_busy !== !er) begin errors++; $display("FAIL %s ready/busy c=%0d got %b/%b exp %b/%b", name, c, o_blk_ready, o_busy, er, !er); end
      checks++; if (o_first !== first) begin errors++; $display("FAIL %s first c=%0d got %b exp %b", name, c, o_first, first); end
      checks++; if (o_sched_block !== blk) begin errors++; $display("FAIL %s block c=%0d got %h exp %h", name, c, o_sched_block[511:480], blk[511:480]); end
`ifdef SHA256_BLK_CTRL_KROM_EN
      if (c >= 2 && c <= 65 && (ei == 6'd0 || ei == 6'd1 || ei == 6'd63)) begin
        ek = ei == 6'd0 ? 32'h428a2f98 : ei == 6'd1 ? 32'h71374491 : 32'hc67178f2;
        checks++; if (o_round_k !== ek) begin errors++; $display("FAIL %s k idx=%0d got %h exp %h", name, ei, o_round_k, ek); end
      end
`else
      ek = 32'h0;
      checks++; if (o_round_k !== ek) begin errors++; $display("FAIL %s k c=%0d got %h exp %h", name, c, o_round_k, ek); end
`endif
      i_abort = c == abort_c;
    end
    i_abort = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (o_blk_ready !== 1'b1 || o_busy !== 1'b0 || o_sched_enable !== 1'b0 || o_round_valid !== 1'b0 ||
        o_round_idx !== 6'd0 || o_round_k !== 32'h0 || o_first !== 1'b0 || o_accumulate !== 1'b0 ||
        o_done !== 1'b0 || o_aborted !== 1'b0 || o_sched_block !== 512'h0) begin
      errors++;
      $display("FAIL %s reset outputs got rdy=%b busy=%b en=%b v=%b idx=%0d k=%h first=%b acc=%b done=%b abt=%b blk0=%h exp rdy=1 others 0",
               name, o_blk_ready, o_busy, o_sched_enable, o_round_valid, o_round_idx, o_round_k, o_first,
               o_accumulate, o_done, o_aborted, o_sched_block[511:480]);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_values("reset_held");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (o_blk_ready !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_release ready/busy got %b/%b exp 1/0", o_blk_ready, o_busy); end
    i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_aborted !== 1'b0) begin errors++; $display("FAIL idle_abort busy/aborted got %b/%b exp 0/0", o_busy, o_aborted); end
  endtask

  task automatic test_abc();
    run_block("abc", ABC, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_block("b2b_1", ABC, 1'b1, 0, 1'b0, 1'b1, B2, 1'b0);
    run_block("b2b_2", B2, 1'b0, 0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_abort_rounds();
    run_block("abort10", B3, 1'b0, 12, 1'b0, 1'b0, '0, 1'b0);
    run_block("after_abort", ABC, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (o_sched_block[511:480] !== 32'h61626380) begin errors++; $display("FAIL after_abort w0 got %h exp 61626380", o_sched_block[511:480]); end
  endtask

  task automatic test_abort_start();
    run_block("abort_start", B2, 1'b1, 1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_abort_63();
    run_block("abort63", B3, 1'b1, 65, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    i_blk_valid = 1'b1; i_blk = B2; i_blk_first = 1'b1;
    @(posedge clk); #1; i_blk_valid = 1'b0;
    repeat (32) @(negedge clk);
    checks++; if (o_round_idx !== 6'd30 || o_round_valid !== 1'b1) begin errors++; $display("FAIL mid_idx got %0d/%b exp 30/1", o_round_idx, o_round_valid); end
    rst = 1'b0; #1;
    check_reset_values("reset_mid");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_block("after_reset", ABC, 1'b1, 0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_back_to_back();
    test_abort_rounds();
    test_abort_start();
    test_abort_63();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
